// File: rtl/descramble_32_pkg.sv
// Shared 64b/66b PCS constants, types and helpers for the 32-bit RX descrambler.
// Tap positions follow G(x) = 1 + x^39 + x^58.
package descramble_32_pkg;
    localparam int WORD_W    = 32;
    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;
    localparam int HIST_W    = SCR_TAP_B;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [HIST_W-1:0] hist_t;

    // Only 01 and 10 are legal 64b/66b sync headers.
    function automatic logic sync_illegal(input logic [1:0] head);
        return (head != SYNC_DATA) && (head != SYNC_CTRL);
    endfunction

    function automatic word_t bit_reverse(input word_t w);
        word_t r;
        for (int i = 0; i < WORD_W; i++) begin
            r[i] = w[WORD_W-1-i];
        end
        return r;
    endfunction
endpackage

// File: rtl/descramble_32_if.sv
// One 32-bit half-block beat of a 66b stream: word, sync header and qualifiers.
// The gearbox drives it as master; the descrambler re-drives the same shape downstream.
interface descramble_32_if;
    import descramble_32_pkg::*;

    word_t      data;
    logic [1:0] head;
    logic       head_vld;
    logic       data_vld;

    modport master (output data, head, head_vld, data_vld);
    modport slave  (input  data, head, head_vld, data_vld);
endinterface

// File: rtl/descramble_32_core.sv
// Combinational self-synchronizing descrambler for one 32-bit word.
// Both taps always reach back into history because the word is shorter than 39 bits.
module descramble_core
    import descramble_32_pkg::*;
(
    input  word_t d,
    input  hist_t hist,
    output word_t out
);
    // The newest seven history bits never land on a tap for a 32-bit word.
    logic unused_hist;
    assign unused_hist = ^hist[SCR_TAP_A-WORD_W-1:0];

    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_bit
            assign out[gi] = d[gi] ^ hist[SCR_TAP_A-1-gi] ^ hist[SCR_TAP_B-1-gi];
        end
    endgenerate
endmodule

// File: rtl/descramble_32.sv
// RX 64b/66b descrambler, 32-bit datapath, fixed 2-clock latency from gearbox to decoder.
// History is fed with received line bits, so the block self-synchronizes after priming.
module descramble_32
    import descramble_32_pkg::*;
#(
    parameter bit BYPASS      = 1'b0,
    parameter int PRIME_WORDS = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    descramble_32_if.slave  rx,
    descramble_32_if.master dec,
    output logic            head_err_o,
    output logic            primed_o
);
    localparam int               CNT_W   = (PRIME_WORDS > 0) ? $clog2(PRIME_WORDS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRIME_WORDS);

    word_t            s1_data_reg;
    logic [1:0]       s1_head_reg;
    logic             s1_head_vld_reg;
    logic             s1_vld_reg;

    hist_t            hist_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             primed_reg;

    word_t            data_reg;
    logic [1:0]       head_reg;
    logic             head_vld_reg;
    logic             data_vld_reg;
    logic             head_err_reg;

    word_t            core_word;
    word_t            out_word_next;

    descramble_core u_core (
        .d    (s1_data_reg),
        .hist (hist_reg),
        .out  (core_word)
    );

    always_comb begin
        cnt_next      = cnt_reg;
        out_word_next = BYPASS ? s1_data_reg : core_word;
        if (s1_vld_reg && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_data_reg     <= '0;
            s1_head_reg     <= '0;
            s1_head_vld_reg <= 1'b0;
            s1_vld_reg      <= 1'b0;
            hist_reg        <= '0;
            cnt_reg         <= '0;
            primed_reg      <= 1'b0;
            data_reg        <= '0;
            head_reg        <= '0;
            head_vld_reg    <= 1'b0;
            data_vld_reg    <= 1'b0;
            head_err_reg    <= 1'b0;
        end else begin
            s1_data_reg     <= rx.data;
            s1_head_reg     <= rx.head;
            s1_head_vld_reg <= rx.head_vld;
            s1_vld_reg      <= rx.data_vld;

            // Gate with the pre-update primed flag so exactly PRIME_WORDS words are dropped.
            head_vld_reg <= s1_head_vld_reg;
            data_vld_reg <= s1_vld_reg & primed_reg;
            head_err_reg <= s1_vld_reg & s1_head_vld_reg & primed_reg & sync_illegal(s1_head_reg);

            cnt_reg    <= cnt_next;
            primed_reg <= (cnt_next == CNT_MAX);

            if (s1_vld_reg) begin
                data_reg <= out_word_next;
                // Shift in the scrambled word, newest bit (d[31]) ending at hist[0].
                hist_reg <= {hist_reg[HIST_W-WORD_W-1:0], bit_reverse(s1_data_reg)};
                if (s1_head_vld_reg) begin
                    head_reg <= s1_head_reg;
                end
            end
        end
    end

    assign dec.data     = data_reg;
    assign dec.head     = head_reg;
    assign dec.head_vld = head_vld_reg;
    assign dec.data_vld = data_vld_reg;
    assign head_err_o   = head_err_reg;
    assign primed_o     = primed_reg;
endmodule

// File: tb/tb_descramble_32.sv
// Bench for descramble_32: bit-stream reference model plus a seeded TX scrambler model,
// driving a normal and a BYPASS instance from the same gearbox stream.
module tb_descramble_32;
    import descramble_32_pkg::*;

    localparam int PRIME = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic head_err, primed, head_err_b, primed_b;

    always #5 clk = ~clk;

    descramble_32_if rx_if ();
    descramble_32_if dec_if ();
    descramble_32_if dec_b_if ();

    descramble_32 #(.BYPASS(1'b0), .PRIME_WORDS(PRIME)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx         (rx_if),
        .dec        (dec_if),
        .head_err_o (head_err),
        .primed_o   (primed)
    );

    descramble_32 #(.BYPASS(1'b1), .PRIME_WORDS(PRIME)) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx         (rx_if),
        .dec        (dec_b_if),
        .head_err_o (head_err_b),
        .primed_o   (primed_b)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] raw;
        logic [31:0] plain;
        logic [1:0]  head;
        logic        head_vld;
        logic        vld;
        logic        err;
        logic        primed;
        logic        chk_plain;
    } exp_t;

    exp_t        q[$];
    bit          line[$];     // scrambled bits received since the last reset, in line order
    bit          tx[$];       // scrambled bits produced by the TX model
    int          nvalid;
    logic [31:0] last_data, last_raw;
    logic [1:0]  last_head;
    int          checks = 0;
    int          errors = 0;
    int          plain_err_bits;
    int          err_seen;
    int          wcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic bit rx_bit(input int j);
        return (j < 0) ? 1'b0 : line[j];
    endfunction

    // TX scrambler seeded with 58'h3: the two most recent pre-stream bits are 1.
    function automatic bit tx_bit(input int j);
        if (j >= 0) return tx[j];
        return (j == -1) || (j == -2);
    endfunction

    task automatic tx_word(input logic [31:0] p, output logic [31:0] s);
        int n;
        for (int k = 0; k < 32; k++) begin
            n = tx.size();
            s[k] = p[k] ^ tx_bit(n - SCR_TAP_A) ^ tx_bit(n - SCR_TAP_B);
            tx.push_back(s[k]);
        end
    endtask

    task automatic check_entry(input exp_t e);
        chk("data_o", dec_if.data, e.data);
        chk("data_vld_o", 32'(dec_if.data_vld), 32'(e.vld));
        chk("head_o", 32'(dec_if.head), 32'(e.head));
        chk("head_vld_o", 32'(dec_if.head_vld), 32'(e.head_vld));
        chk("head_err_o", 32'(head_err), 32'(e.err));
        chk("primed_o", 32'(primed), 32'(e.primed));
        chk("byp_data_o", dec_b_if.data, e.raw);
        chk("byp_data_vld_o", 32'(dec_b_if.data_vld), 32'(e.vld));
        chk("byp_primed_o", 32'(primed_b), 32'(e.primed));
        if (head_err) err_seen++;
        if (e.chk_plain && dec_if.data_vld) plain_err_bits += $countones(dec_if.data ^ e.plain);
    endtask

    task automatic step(input logic [31:0] d, input logic [1:0] h, input logic hv,
                        input logic v, input logic [31:0] plain, input logic chkp);
        exp_t        e;
        logic [31:0] dd;
        int          base;
        rx_if.data     = d;
        rx_if.head     = h;
        rx_if.head_vld = hv;
        rx_if.data_vld = v;
        e.vld = 1'b0;
        e.err = 1'b0;
        if (v) begin
            base = line.size();
            for (int k = 0; k < 32; k++) begin
                dd[k] = d[k] ^ rx_bit(base + k - SCR_TAP_A) ^ rx_bit(base + k - SCR_TAP_B);
            end
            for (int k = 0; k < 32; k++) line.push_back(d[k]);
            e.vld = (nvalid >= PRIME);
            e.err = hv && (nvalid >= PRIME) && (h == 2'b00 || h == 2'b11);
            nvalid++;
            last_data = dd;
            last_raw  = d;
            if (hv) last_head = h;
        end
        e.primed    = (nvalid >= PRIME);
        e.data      = last_data;
        e.raw       = last_raw;
        e.head      = last_head;
        e.head_vld  = hv;
        e.plain     = plain;
        e.chk_plain = chkp && v;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() >= 2) check_entry(q.pop_front());
    endtask

    task automatic pause_step();
        step($urandom, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] s, input logic [1:0] h, input logic hv,
                             input logic [31:0] plain);
        step(s, h, hv, 1'b1, plain, 1'b1);
        wcnt++;
        if (wcnt % 32 == 0) pause_step();
    endtask

    function automatic logic [1:0] legal_head();
        return ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL;
    endfunction

    task automatic send_block(input logic [1:0] h1, input logic [1:0] h2,
                              input logic [31:0] inj, input int mid_pauses);
        logic [63:0] p;
        logic [31:0] s;
        p = {$urandom, $urandom};
        tx_word(p[31:0], s);
        send_word(s ^ inj, h1, 1'b1, p[31:0]);
        for (int i = 0; i < mid_pauses; i++) pause_step();
        tx_word(p[63:32], s);
        send_word(s, h2, 1'b0, p[63:32]);
    endtask

    task automatic do_reset(input logic [31:0] d);
        exp_t z;
        rst            = 1'b1;
        rx_if.data     = d;
        rx_if.head     = SYNC_DATA;
        rx_if.head_vld = 1'b1;
        rx_if.data_vld = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_data_o", dec_if.data, 32'h0);
        chk("rst_data_vld_o", 32'(dec_if.data_vld), 32'h0);
        chk("rst_head_o", 32'(dec_if.head), 32'h0);
        chk("rst_head_vld_o", 32'(dec_if.head_vld), 32'h0);
        chk("rst_head_err_o", 32'(head_err), 32'h0);
        chk("rst_primed_o", 32'(primed), 32'h0);
        chk("rst_byp_data_o", dec_b_if.data, 32'h0);
        rst = 1'b0;
        q.delete();
        line.delete();
        nvalid    = 0;
        last_data = '0;
        last_raw  = '0;
        last_head = '0;
        z = '{default: '0};
        q.push_back(z);
    endtask

    task automatic drain();
        pause_step();
        pause_step();
    endtask

    initial begin
        logic [31:0] s;
        rx_if.data = '0; rx_if.head = '0; rx_if.head_vld = 1'b0; rx_if.data_vld = 1'b0;

        // All-zero scrambled stream: data stays 0, primed after the second word.
        do_reset(32'h0);
        plain_err_bits = 0;
        for (int i = 0; i < 6; i++) step(32'h0, SYNC_DATA, (i % 2 == 0), 1'b1, 32'h0, 1'b1);
        drain();
        chk("zero_stream_plain_bits", 32'(plain_err_bits), 32'h0);

        // Loopback from the seeded TX scrambler, with a 3-cycle pause mid-block.
        do_reset($urandom);
        plain_err_bits = 0;
        for (int b = 0; b < 200; b++) begin
            send_block(legal_head(), legal_head(), 32'h0, (b == 100) ? 3 : 0);
        end
        drain();
        chk("loopback_plain_bits", 32'(plain_err_bits), 32'h0);

        // Illegal headers on first halves pulse; legal ones and second-half 11 do not.
        err_seen = 0;
        send_block(2'b11, legal_head(), 32'h0, 0);
        send_block(2'b00, legal_head(), 32'h0, 0);
        send_block(SYNC_DATA, legal_head(), 32'h0, 0);
        send_block(SYNC_CTRL, legal_head(), 32'h0, 0);
        send_block(SYNC_DATA, 2'b11, 32'h0, 0);
        drain();
        chk("head_err_pulses", 32'(err_seen), 32'd2);

        // One line bit error multiplies into exactly three output bit errors.
        plain_err_bits = 0;
        send_block(legal_head(), legal_head(), 32'h0000_0020, 0);
        for (int b = 0; b < 4; b++) send_block(legal_head(), legal_head(), 32'h0, 0);
        drain();
        chk("bit_error_spread", 32'(plain_err_bits), 32'd3);

        // One-cycle reset in the middle of a block, then resynchronization.
        begin
            logic [63:0] p;
            p = {$urandom, $urandom};
            tx_word(p[31:0], s);
            send_word(s, legal_head(), 1'b1, p[31:0]);
            tx_word(p[63:32], s);
            do_reset(s);
        end
        plain_err_bits = 0;
        for (int b = 0; b < 8; b++) send_block(legal_head(), legal_head(), 32'h0, 0);
        drain();
        chk("post_reset_plain_bits", 32'(plain_err_bits), 32'h0);
        chk("post_reset_primed", 32'(primed), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
